sample_fifo: RTL and testbench

SAMPLE_FIFO -- requirements
Module: sample_fifo

---
 rtl/sample_fifo.sv | 118 +++++++++++
 tb/tb_sample_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a registered read port, level-derived status flags,
// sticky overflow/underflow errors, and a selectable drop-new or overwrite-oldest policy when full.
module sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = 1,
    parameter int OVERWRITE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we,
    input  logic                  re,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam logic OVW = (OVERWRITE != 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic          w_empty;
    logic          w_full;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_full_wr;
    logic          w_rd_adv;
    logic          w_udf_evt;
    logic [LW-1:0] w_level_next;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    always_comb begin
        w_rd_acc     = re & ~w_empty & ~flush;
        // Write while full with no read to make room: dropped or overwriting, but always an error.
        w_full_wr    = we & ~flush & w_full & ~w_rd_acc;
        w_wr_acc     = we & ~flush & (~w_full | w_rd_acc | OVW);
        w_rd_adv     = w_rd_acc | (w_full_wr & OVW);
        w_udf_evt    = re & w_empty & ~flush;
        w_level_next = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   if (!w_full) w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Memory is intentionally left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Read-first: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_rd_adv) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            r_level     <= w_level_next;
            r_overflow  <= (r_overflow & ~clr_err) | w_full_wr;
            r_underflow <= (r_underflow & ~clr_err) | w_udf_evt;
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign level        = r_level;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_level >= LW'(AFULL_LVL));
    assign almost_empty = (r_level <= LW'(AEMPTY_LVL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: one drop-mode and one overwrite-mode instance share stimulus.
module tb_sample_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in = '0;
    logic        we = 1'b0, re = 1'b0, flush = 1'b0, clr_err = 1'b0;

    logic [15:0] dout_d, dout_o;
    logic        dv_d, dv_o;
    logic [2:0]  lvl_d, lvl_o;
    logic        emp_d, ful_d, ae_d, af_d, ovf_d, udf_d;
    logic        emp_o, ful_o, ae_o, af_o, ovf_o, udf_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sample_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .OVERWRITE(0)) u_drop (
        .clk(clk), .rst(rst), .data_in(data_in), .we(we), .re(re), .flush(flush), .clr_err(clr_err),
        .data_out(dout_d), .data_valid(dv_d), .level(lvl_d), .empty(emp_d), .full(ful_d),
        .almost_empty(ae_d), .almost_full(af_d), .overflow(ovf_d), .underflow(udf_d));

    sample_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .OVERWRITE(1)) u_ovw (
        .clk(clk), .rst(rst), .data_in(data_in), .we(we), .re(re), .flush(flush), .clr_err(clr_err),
        .data_out(dout_o), .data_valid(dv_o), .level(lvl_o), .empty(emp_o), .full(ful_o),
        .almost_empty(ae_o), .almost_full(af_o), .overflow(ovf_o), .underflow(udf_o));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] d);
        data_in = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; re = 1'b1; data_in = 16'hFFFF;
        tick();
        rst = 1'b0; we = 1'b0; re = 1'b0;
        checks++;
        if ({dout_d, dv_d, lvl_d, ovf_d, udf_d} !== {16'h0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_state_drop got dout=%h dv=%b lvl=%0d ovf=%b udf=%b", dout_d, dv_d, lvl_d, ovf_d, udf_d);
        end
        checks++;
        if ({dout_o, dv_o, lvl_o, ovf_o, udf_o} !== {16'h0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_state_ovw got dout=%h dv=%b lvl=%0d ovf=%b udf=%b", dout_o, dv_o, lvl_o, ovf_o, udf_o);
        end
        checks++;
        if ({emp_d, ful_d, ae_d, af_d} !== 4'b1010) begin
            failures++; $display("FAIL reset_flags got e/f/ae/af=%b%b%b%b exp 1010", emp_d, ful_d, ae_d, af_d);
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) begin
            write_word(16'(i));
            if (i == 3) begin
                checks++;
                if ({lvl_d, af_d, ful_d, ae_d} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
                    failures++; $display("FAIL basic_lvl3 got lvl=%0d af=%b full=%b ae=%b exp 3 1 0 0", lvl_d, af_d, ful_d, ae_d);
                end
            end
        end
        checks++;
        if ({lvl_d, ful_d, emp_d} !== {3'd4, 1'b1, 1'b0}) begin
            failures++; $display("FAIL basic_full got lvl=%0d full=%b empty=%b exp 4 1 0", lvl_d, ful_d, emp_d);
        end
        re = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({dout_d, dv_d, dout_o, dv_o} !== {16'(i), 1'b1, 16'(i), 1'b1}) begin
                failures++; $display("FAIL basic_read%0d got d=%h/%b o=%h/%b exp %h/1", i, dout_d, dv_d, dout_o, dv_o, 16'(i));
            end
        end
        re = 1'b0;
        tick();
        checks++;
        if ({dout_d, dv_d, emp_d, ae_d, lvl_d} !== {16'h0004, 1'b0, 1'b1, 1'b1, 3'd0}) begin
            failures++; $display("FAIL basic_end got dout=%h dv=%b e=%b ae=%b lvl=%0d exp 0004 0 1 1 0", dout_d, dv_d, emp_d, ae_d, lvl_d);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) write_word(16'(i));
        write_word(16'h0005);
        checks++;
        if ({ovf_d, lvl_d, ovf_o, lvl_o} !== {1'b1, 3'd4, 1'b1, 3'd4}) begin
            failures++; $display("FAIL ovf_flag got d=%b/%0d o=%b/%0d exp 1/4", ovf_d, lvl_d, ovf_o, lvl_o);
        end
        re = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({dout_d, dout_o} !== {16'(i), 16'(i + 1)}) begin
                failures++; $display("FAIL ovf_read%0d got drop=%h ovw=%h exp %h %h", i, dout_d, dout_o, 16'(i), 16'(i + 1));
            end
        end
        re = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if ({ovf_d, ovf_o, emp_d, emp_o} !== 4'b0011) begin
            failures++; $display("FAIL ovf_clear got ovf=%b%b empty=%b%b exp 00 11", ovf_d, ovf_o, emp_d, emp_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'h0002; exp_q[1] = 16'h0003; exp_q[2] = 16'h0004; exp_q[3] = 16'h00AA;
        for (int i = 1; i <= 4; i++) write_word(16'(i));
        data_in = 16'h00AA; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0;
        checks++;
        if ({dout_d, dv_d, lvl_d, ovf_d, dout_o, lvl_o, ovf_o} !== {16'h0001, 1'b1, 3'd4, 1'b0, 16'h0001, 3'd4, 1'b0}) begin
            failures++; $display("FAIL b2b_full got d=%h dv=%b lvl=%0d ovf=%b o=%h lvl=%0d ovf=%b", dout_d, dv_d, lvl_d, ovf_d, dout_o, lvl_o, ovf_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({dout_d, dout_o} !== {exp_q[i], exp_q[i]}) begin
                failures++; $display("FAIL b2b_read%0d got %h %h exp %h", i, dout_d, dout_o, exp_q[i]);
            end
        end
        re = 1'b0;
        tick();
        checks++;
        if ({lvl_d, lvl_o} !== 6'd0) begin
            failures++; $display("FAIL b2b_drain got lvl=%0d/%0d exp 0", lvl_d, lvl_o);
        end
    endtask

    task automatic test_underflow();
        re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if ({dv_d, dout_d, udf_d, udf_o} !== {1'b0, 16'h00AA, 1'b1, 1'b1}) begin
            failures++; $display("FAIL udf_set got dv=%b dout=%h udf=%b%b exp 0 00aa 11", dv_d, dout_d, udf_d, udf_o);
        end
        clr_err = 1'b1;
        tick();
        checks++;
        if ({udf_d, udf_o} !== 2'b00) begin
            failures++; $display("FAIL udf_clear got %b%b exp 00", udf_d, udf_o);
        end
        re = 1'b1;
        tick();
        checks++;
        if ({udf_d, udf_o} !== 2'b11) begin
            failures++; $display("FAIL udf_clr_collide got %b%b exp 11", udf_d, udf_o);
        end
        re = 1'b0;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_flush();
        re = 1'b1;
        tick();
        re = 1'b0;
        for (int i = 0; i < 3; i++) write_word(16'h0100 + 16'(i));
        data_in = 16'h0077; we = 1'b1; flush = 1'b1;
        tick();
        we = 1'b0; flush = 1'b0;
        checks++;
        if ({lvl_d, emp_d, udf_d, ovf_d, dv_d, dout_d} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA}) begin
            failures++; $display("FAIL flush_state got lvl=%0d e=%b udf=%b ovf=%b dv=%b dout=%h", lvl_d, emp_d, udf_d, ovf_d, dv_d, dout_d);
        end
        write_word(16'h0055);
        re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if ({dout_d, dout_o, lvl_d} !== {16'h0055, 16'h0055, 3'd0}) begin
            failures++; $display("FAIL flush_discard got %h %h lvl=%0d exp 0055 0", dout_d, dout_o, lvl_d);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        write_word(16'h0011);
        write_word(16'h0022);
        re = 1'b1; rst = 1'b1;
        tick();
        re = 1'b0; rst = 1'b0;
        checks++;
        if ({lvl_d, dout_d, dv_d, lvl_o, dout_o} !== {3'd0, 16'h0, 1'b0, 3'd0, 16'h0}) begin
            failures++; $display("FAIL rst_mid got lvl=%0d dout=%h dv=%b o_lvl=%0d o_dout=%h", lvl_d, dout_d, dv_d, lvl_o, dout_o);
        end
        write_word(16'h0BEE);
        re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if ({dout_d, dv_d, dout_o} !== {16'h0BEE, 1'b1, 16'h0BEE}) begin
            failures++; $display("FAIL rst_mid_read got %h dv=%b %h exp 0bee", dout_d, dv_d, dout_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
